// File: rtl/merge_input_if.sv
// Button/bus bundle for the time-entry block.
// master: button logic side; slave: merge_input side.
interface merge_input_if;
    logic       edit_req;
    logic       inc;
    logic       next;
    logic       cancel;
`ifdef MERGE_INPUT_DEC_EN
    logic       dec;
`endif
    logic [7:0] init_total;
    logic [3:0] left;
    logic [3:0] right;
    logic       editing;
    logic       sel;
    logic [7:0] total;
    logic       total_valid;

    modport master (
`ifdef MERGE_INPUT_DEC_EN
        output dec,
`endif
        output edit_req, inc, next, cancel, init_total,
        input  left, right, editing, sel, total, total_valid
    );

    modport slave (
`ifdef MERGE_INPUT_DEC_EN
        input  dec,
`endif
        input  edit_req, inc, next, cancel, init_total,
        output left, right, editing, sel, total, total_valid
    );
endinterface

// File: rtl/merge_input.sv
// Time-entry block: edit a value as tens/ones digits, commit binary total.
// Ports: clk, rst_n (async, active-low), bus (merge_input_if.slave).
// Optional MERGE_INPUT_DEC_EN adds the dec button (decrement digit).
module merge_input #(
    parameter int MAX_VAL = 59
) (
    input  logic         clk,
    input  logic         rst_n,
    merge_input_if.slave bus
);
    localparam logic [7:0] MAXV = 8'(MAX_VAL);
    localparam logic [3:0] MAXT = 4'(MAX_VAL / 10);
    localparam logic [3:0] MAXO = 4'(MAX_VAL % 10);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_TENS,
        S_ONES
    } state_t;

    state_t     r_state;
    state_t     w_nstate;
    logic [7:0] r_rem;
    logic [3:0] r_left;
    logic [3:0] r_right;
    logic [7:0] r_total;
    logic       r_tv;

    logic       w_editing;
    logic       w_sel;
    logic [7:0] w_clamp;
    logic [3:0] w_t_up;
    logic [3:0] w_lim;
    logic [3:0] w_o_up;
    logic [7:0] w_sum;
    logic [3:0] w_tot_t;
    logic [3:0] w_tot_o;
`ifdef MERGE_INPUT_DEC_EN
    logic [3:0] w_t_dn;
    logic [3:0] w_o_dn;
`endif

    assign w_clamp = (bus.init_total > MAXV) ? MAXV : bus.init_total;
    assign w_t_up  = (r_left >= MAXT) ? 4'd0 : r_left + 4'd1;
    assign w_lim   = (r_left == MAXT) ? MAXO : 4'd9;
    assign w_o_up  = (r_right >= w_lim) ? 4'd0 : r_right + 4'd1;
`ifdef MERGE_INPUT_DEC_EN
    assign w_t_dn  = (r_left == 4'd0) ? MAXT : r_left - 4'd1;
    assign w_o_dn  = (r_right == 4'd0) ? w_lim : r_right - 4'd1;
`endif
    // tens*10 + ones without a multiplier
    assign w_sum   = ({4'd0, r_left} << 3) + ({4'd0, r_left} << 1)
                   + {4'd0, r_right};
    // digits of the committed total, used when an edit is cancelled
    assign w_tot_t = 4'(r_total / 8'd10);
    assign w_tot_o = 4'(r_total % 8'd10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            S_IDLE: if (bus.edit_req) w_nstate = S_LOAD;
            S_LOAD: if (r_rem < 8'd10) w_nstate = S_TENS;
            S_TENS: begin
                if (bus.cancel)    w_nstate = S_IDLE;
                else if (bus.next) w_nstate = S_ONES;
            end
            S_ONES: begin
                if (bus.cancel || bus.next) w_nstate = S_IDLE;
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    always_comb begin
        w_editing = (r_state != S_IDLE);
        w_sel     = (r_state == S_ONES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem   <= 8'd0;
            r_left  <= 4'd0;
            r_right <= 4'd0;
            r_total <= 8'd0;
            r_tv    <= 1'b0;
        end else begin
            r_tv <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.edit_req) begin
                        r_rem  <= w_clamp;
                        r_left <= 4'd0;
                    end
                end
                S_LOAD: begin
                    // one decimal subtraction per cycle
                    if (r_rem >= 8'd10) begin
                        r_rem  <= r_rem - 8'd10;
                        r_left <= r_left + 4'd1;
                    end else begin
                        r_right <= r_rem[3:0];
                    end
                end
                S_TENS: begin
                    if (bus.cancel) begin
                        r_left  <= w_tot_t;
                        r_right <= w_tot_o;
                    end else if (bus.next) begin
                        r_left <= r_left;
                    end else if (bus.inc) begin
                        r_left <= w_t_up;
                        if (w_t_up == MAXT && r_right > MAXO)
                            r_right <= MAXO;
                    end
`ifdef MERGE_INPUT_DEC_EN
                    else if (bus.dec) begin
                        r_left <= w_t_dn;
                        if (w_t_dn == MAXT && r_right > MAXO)
                            r_right <= MAXO;
                    end
`endif
                end
                S_ONES: begin
                    if (bus.cancel) begin
                        r_left  <= w_tot_t;
                        r_right <= w_tot_o;
                    end else if (bus.next) begin
                        r_total <= w_sum;
                        r_tv    <= 1'b1;
                    end else if (bus.inc) begin
                        r_right <= w_o_up;
                    end
`ifdef MERGE_INPUT_DEC_EN
                    else if (bus.dec) begin
                        r_right <= w_o_dn;
                    end
`endif
                end
                default: r_rem <= 8'd0;
            endcase
        end
    end

    assign bus.left        = r_left;
    assign bus.right       = r_right;
    assign bus.editing     = w_editing;
    assign bus.sel         = w_sel;
    assign bus.total       = r_total;
    assign bus.total_valid = r_tv;
endmodule

// File: tb/tb_merge_input.sv
// Directed bench for merge_input (MAX_VAL 59 and 45 instances).
// Commits of the 59 instance are checked through an expected-total queue.
module tb_merge_input;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    merge_input_if a ();
    merge_input_if b ();

    merge_input #(.MAX_VAL(59)) u59 (.clk(clk), .rst_n(rst_n), .bus(a));
    merge_input #(.MAX_VAL(45)) u45 (.clk(clk), .rst_n(rst_n), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drv59(logic er, logic in, logic nx, logic cn,
                         logic [7:0] it);
        a.edit_req = er; a.inc = in; a.next = nx;
        a.cancel = cn; a.init_total = it;
        @(negedge clk);
        a.edit_req = 0; a.inc = 0; a.next = 0; a.cancel = 0;
    endtask

    task automatic drv45(logic er, logic in, logic nx, logic cn,
                         logic [7:0] it);
        b.edit_req = er; b.inc = in; b.next = nx;
        b.cancel = cn; b.init_total = it;
        @(negedge clk);
        b.edit_req = 0; b.inc = 0; b.next = 0; b.cancel = 0;
    endtask

`ifdef MERGE_INPUT_DEC_EN
    task automatic dec59();
        a.dec = 1'b1;
        @(negedge clk);
        a.dec = 1'b0;
    endtask
`endif

    // scoreboard: every total_valid pulse must match a queued commit
    always @(negedge clk) begin
        if (rst_n && a.total_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 8'd1, 8'd0);
            end else begin
                chk("commit_total", a.total, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a.edit_req = 0; a.inc = 0; a.next = 0; a.cancel = 0;
        a.init_total = 0;
        b.edit_req = 0; b.inc = 0; b.next = 0; b.cancel = 0;
        b.init_total = 0;
`ifdef MERGE_INPUT_DEC_EN
        a.dec = 0; b.dec = 0;
`endif
        cyc(2);
        chk("rst_editing", {7'd0, a.editing}, 8'd0);
        chk("rst_tv", {7'd0, a.total_valid}, 8'd0);
        rst_n = 1'b1;
        cyc(1);
        chk("post_rst_left", {4'd0, a.left}, 8'd0);
        chk("post_rst_right", {4'd0, a.right}, 8'd0);
        chk("post_rst_total", a.total, 8'd0);
        chk("post_rst_sel", {7'd0, a.sel}, 8'd0);

        // split 47: five LOAD cycles
        drv59(1, 0, 0, 0, 8'd47);
        chk("load_editing", {7'd0, a.editing}, 8'd1);
        cyc(5);
        chk("split47_left", {4'd0, a.left}, 8'd4);
        chk("split47_right", {4'd0, a.right}, 8'd7);
        chk("split47_editing", {7'd0, a.editing}, 8'd1);
        chk("split47_sel", {7'd0, a.sel}, 8'd0);
        drv59(0, 0, 0, 1, 8'd0);
        chk("cancel47_editing", {7'd0, a.editing}, 8'd0);
        chk("cancel47_left", {4'd0, a.left}, 8'd0);

        // clamp 200 -> 59, six LOAD cycles
        drv59(1, 0, 0, 0, 8'd200);
        cyc(6);
        chk("clamp_left", {4'd0, a.left}, 8'd5);
        chk("clamp_right", {4'd0, a.right}, 8'd9);
        drv59(0, 0, 1, 0, 8'd0);
        chk("ones_sel", {7'd0, a.sel}, 8'd1);
        exp_q.push_back(8'd59);
        drv59(0, 0, 1, 0, 8'd0);
        chk("commit59_tv", {7'd0, a.total_valid}, 8'd1);
        chk("commit59_editing", {7'd0, a.editing}, 8'd0);
        cyc(1);
        chk("commit59_tv_clear", {7'd0, a.total_valid}, 8'd0);

        // next beats inc on the commit edge
        drv59(1, 0, 0, 0, 8'd12);
        cyc(2);
        chk("split12_left", {4'd0, a.left}, 8'd1);
        chk("split12_right", {4'd0, a.right}, 8'd2);
        drv59(0, 0, 1, 0, 8'd0);
        exp_q.push_back(8'd12);
        drv59(0, 1, 1, 0, 8'd0);
        chk("prio_right", {4'd0, a.right}, 8'd2);
        cyc(1);

        // cancel beats next: no commit
        drv59(1, 0, 0, 0, 8'd33);
        cyc(4);
        drv59(0, 1, 0, 0, 8'd0);
        chk("inc_tens_left", {4'd0, a.left}, 8'd4);
        drv59(0, 0, 1, 0, 8'd0);
        drv59(0, 0, 1, 1, 8'd0);
        chk("cancel_editing", {7'd0, a.editing}, 8'd0);
        chk("cancel_total", a.total, 8'd12);
        chk("cancel_left", {4'd0, a.left}, 8'd1);
        chk("cancel_right", {4'd0, a.right}, 8'd2);
        cyc(2);

        // MAX_VAL 45: tens wrap and ones clamp
        drv45(1, 0, 0, 0, 8'd39);
        cyc(4);
        chk("m45_left", {4'd0, b.left}, 8'd3);
        chk("m45_right", {4'd0, b.right}, 8'd9);
        drv45(0, 1, 0, 0, 8'd0);
        chk("m45_clamp_left", {4'd0, b.left}, 8'd4);
        chk("m45_clamp_right", {4'd0, b.right}, 8'd5);
        drv45(0, 1, 0, 0, 8'd0);
        chk("m45_wrap_left", {4'd0, b.left}, 8'd0);
        chk("m45_wrap_right", {4'd0, b.right}, 8'd5);
        for (int i = 0; i < 4; i++) drv45(0, 1, 0, 0, 8'd0);
        chk("m45_back_left", {4'd0, b.left}, 8'd4);
        drv45(0, 0, 1, 0, 8'd0);
        drv45(0, 1, 0, 0, 8'd0);
        chk("m45_ones_wrap", {4'd0, b.right}, 8'd0);
        drv45(0, 0, 1, 0, 8'd0);
        chk("m45_total", b.total, 8'd40);
        chk("m45_tv", {7'd0, b.total_valid}, 8'd1);
        cyc(1);
        chk("m45_tv_clear", {7'd0, b.total_valid}, 8'd0);

`ifdef MERGE_INPUT_DEC_EN
        drv59(1, 0, 0, 0, 8'd0);
        cyc(1);
        dec59();
        chk("dec_tens_wrap", {4'd0, a.left}, 8'd5);
        drv59(0, 0, 1, 0, 8'd0);
        dec59();
        chk("dec_ones_wrap", {4'd0, a.right}, 8'd9);
        drv59(0, 0, 0, 1, 8'd0);
`endif

        // reset mid-LOAD
        drv59(1, 0, 0, 0, 8'd47);
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_editing", {7'd0, a.editing}, 8'd0);
        chk("midrst_left", {4'd0, a.left}, 8'd0);
        chk("midrst_total", a.total, 8'd0);
        chk("midrst_total45", b.total, 8'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("after_rst_editing", {7'd0, a.editing}, 8'd0);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/merge_input.md
# merge_input

Time-entry block for the digital clock: the inverse of the binary-to-digit split. Lets the user edit a minutes/seconds value as two decimal digits (tens, ones) using single-cycle button pulses. On commit it reassembles the digits into an 8-bit binary total for the counter. It sits between the debounced button logic and the time counters, and drives the display digit outputs while editing.

## Interface
- MAX_VAL, 59: largest committable binary value; legal range 9..99.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- edit_req  in  1  one-cycle pulse: start editing. Ignored unless in IDLE.
- inc  in  1  one-cycle pulse: increment the selected digit.
- next  in  1  one-cycle pulse: advance tens→ones, or commit from ones.
- cancel  in  1  one-cycle pulse: abort the edit without committing.
- init_total  in  8  binary value sampled on edit_req.
- left  out  4  tens digit (BCD), registered.
- right  out  4  ones digit (BCD), registered.
- editing  out  1  high in LOAD, EDIT_TENS and EDIT_ONES.
- sel  out  1  0 = tens selected, 1 = ones selected; 0 outside EDIT_ONES.
- total  out  8  last committed binary value, registered.
- total_valid  out  1  one-cycle pulse on commit.

## Operation
- States: IDLE, LOAD, EDIT_TENS, EDIT_ONES.
- Reset (async, rst_n=0):
  - state=IDLE.
  - left, right, total, total_valid, editing, sel all 0.
  - Internal remainder register cleared.
- IDLE:
  - left/right show the digits of `total`.
  - On edit_req: remainder ← min(init_total, MAX_VAL); tens ← 0; go to LOAD.
- LOAD (sequential decimal split):
  - If remainder ≥ 10: remainder −= 10; tens += 1.
  - Otherwise: ones ← remainder; go to EDIT_TENS.
  - Inputs other than rst_n are ignored in this state.
- EDIT_TENS:
  - inc: tens += 1, wrapping from MAX_VAL/10 to 0.
  - If the new tens equals MAX_VAL/10 and ones > MAX_VAL%10, ones is clamped to MAX_VAL%10 on the same edge.
  - next → EDIT_ONES.
- EDIT_ONES:
  - inc: ones += 1. Upper limit is 9, or MAX_VAL%10 when tens = MAX_VAL/10; at the limit it wraps to 0.
  - next: total ← tens×10 + ones, computed as (tens<<3)+(tens<<1)+ones in 8 bits; total_valid ← 1; go to IDLE.
- cancel in any edit state: go to IDLE immediately; total is unchanged, no pulse; left/right revert to the digits of `total`.
- Input priority within one cycle: cancel > next > inc (> dec). Only the highest-priority input acts.
- The committed total never exceeds MAX_VAL.

## Timing
- edit_req sampled at edge n → LOAD from n+1; LOAD lasts (clamped value / 10) + 1 cycles; editing=1 from edge n.
- left/right update on the same edge as the inc/dec that changes them; latency 1 cycle.
- next in EDIT_ONES at edge k: total and total_valid valid after edge k; total_valid clears after edge k+1; state=IDLE after edge k.
- rst_n asserted mid-edit or mid-LOAD: immediate return to the reset values; no commit.
- edit_req coincident with total_valid (commit edge) is ignored, since the state was not yet IDLE.

## Configuration
- MERGE_INPUT_DEC_EN:
  - Defined: adds input port `dec` (1 bit, pulse) with priority below inc.
    - Decrements the selected digit.
    - Tens wraps 0 → MAX_VAL/10, applying the same ones clamp as inc.
    - Ones wraps 0 → current limit (9 or MAX_VAL%10).
  - Undefined: no `dec` port; digits are only incrementable.

## Test plan
- Reset: hold rst_n=0 mid-operation → all outputs 0, state IDLE. After release, left=0, right=0, total=0.
- Load/split: edit_req with init_total=47 → 5 LOAD cycles, then EDIT_TENS with left=4, right=7, editing=1, sel=0.
- Clamp: init_total=200, MAX_VAL=59 → left=5, right=9. Commit → total=59, total_valid high for exactly 1 cycle.
- Tens wrap and ones clamp, MAX_VAL=45:
  - Start 39; inc tens → left=4, right=5 (clamped).
  - inc tens again → left=0, right=5.
  - In EDIT_ONES at tens=4, ones=5: inc → right=0.
- Cancel and priority:
  - In EDIT_ONES with total=12, assert next and inc in the same cycle → commit happens; the digit does not change first.
  - Separately, assert cancel+next together → IDLE, total stays 12, no pulse.
- Dec (macro on): at left=0, dec in EDIT_TENS with MAX_VAL=59 → left=5. In EDIT_ONES at right=0 → right=9.
